// File: rtl/ntsc_pkg.sv
// NTSC scan-controller shared definitions.
// Holds the default horizontal/vertical timing constants, the DAC level
// select encoding consumed by the level encoder, and the line-type
// enumeration produced by the line classifier.
package ntsc_pkg;

  // Default timing (pixel clock 6.293761309 MHz)
  localparam int H_TOTAL_D     = 400;
  localparam int H_SYNC_D      = 29;
  localparam int H_EQ_D        = 13;
  localparam int H_HALF_D      = 200;
  localparam int H_SERR_D      = 170;
  localparam int H_ACT_FIRST_D = 58;
  localparam int H_ACT_LAST_D  = 388;
  localparam int V_ACT_FIRST_D = 19;
  localparam int V_ACT_LAST_D  = 261;
  localparam int V_LINES_F1_D  = 263;
  localparam int V_LINES_F0_D  = 262;

  // level_sel encoding
  localparam logic [1:0] LVL_SYNC  = 2'd0;
  localparam logic [1:0] LVL_BLANK = 2'd1;
  localparam logic [1:0] LVL_IDLE  = 2'd2;
  localparam logic [1:0] LVL_DATA  = 2'd3;

  // Line types: EQ/SERR use the same low width in both half-lines,
  // HALF_x_y lines use width x in the first half and y in the second.
  typedef enum logic [2:0] {
    LT_EQ,
    LT_SERR,
    LT_HALF_EQ_SERR,
    LT_HALF_SERR_EQ,
    LT_BLANK,
    LT_ACTIVE
  } line_type_t;

endpackage

// File: rtl/ntsc_line_classifier.sv
// Combinational map from (field, line_count) to the line type.
// Ports:
//   field      - 1 = even field (263 lines), 0 = odd field (262 lines)
//   line_count - line within the field
//   line_type  - classification used by the parent to place sync edges
module ntsc_line_classifier
  import ntsc_pkg::*;
#(
  parameter int V_ACT_FIRST = V_ACT_FIRST_D,
  parameter int V_ACT_LAST  = V_ACT_LAST_D
) (
  input  logic       field,
  input  logic [8:0] line_count,
  output line_type_t line_type
);

  localparam logic [8:0] ACT_F = 9'(V_ACT_FIRST);
  localparam logic [8:0] ACT_L = 9'(V_ACT_LAST);

  always_comb begin
    line_type = LT_BLANK;
    if (line_count >= ACT_F && line_count <= ACT_L) line_type = LT_ACTIVE;
    // Vertical interval lines take precedence over the active range.
    if (line_count <= 9'd8) begin
      if (field) begin
        if (line_count >= 9'd3 && line_count <= 9'd5) line_type = LT_SERR;
        else line_type = LT_EQ;
      end else begin
        case (line_count)
          9'd0, 9'd1, 9'd6, 9'd7: line_type = LT_EQ;
          9'd2:                   line_type = LT_HALF_EQ_SERR;
          9'd3, 9'd4:             line_type = LT_SERR;
          9'd5:                   line_type = LT_HALF_SERR_EQ;
          default:                line_type = LT_BLANK;
        endcase
      end
    end
  end

endmodule

// File: rtl/ntsc_scan_ctrl.sv
// NTSC horizontal/vertical/field sequencer and FIFO read scheduler.
// Ports:
//   clk, rst        - pixel clock, asynchronous active-high reset
//   enable          - data-window enable, latched at each field start
//   fifo_empty      - show-ahead FIFO empty flag
//   fifo_rdreq      - read acknowledge (word on q consumed this cycle)
//   sync            - composite sync, 0 = sync tip
//   level_sel       - SYNC / BLANK / IDLE / DATA to the level encoder
//   pixel_count     - 0..H_TOTAL-1
//   line_count      - line within the field
//   field           - 1 = even (263 lines), 0 = odd (262 lines)
//   field_start     - one-cycle pulse at pixel 0, line 0
//   underrun_count  - saturating count of data-window pixels with FIFO empty
//
// Timing state and outputs are computed from the next counter values and
// registered together, so every output lines up with the counts shown in
// the same cycle. The only combinational path is the fifo_empty gate on
// fifo_rdreq / DATA: a show-ahead FIFO needs the acknowledge to match the
// current empty flag, otherwise the last word could be read twice.
module ntsc_scan_ctrl
  import ntsc_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_D,
  parameter int H_SYNC      = H_SYNC_D,
  parameter int H_EQ        = H_EQ_D,
  parameter int H_HALF      = H_HALF_D,
  parameter int H_SERR      = H_SERR_D,
  parameter int H_ACT_FIRST = H_ACT_FIRST_D,
  parameter int H_ACT_LAST  = H_ACT_LAST_D,
  parameter int V_ACT_FIRST = V_ACT_FIRST_D,
  parameter int V_ACT_LAST  = V_ACT_LAST_D,
  parameter int V_LINES_F1  = V_LINES_F1_D,
  parameter int V_LINES_F0  = V_LINES_F0_D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  output logic        fifo_rdreq,
  output logic        sync,
  output logic [1:0]  level_sel,
  output logic [8:0]  pixel_count,
  output logic [8:0]  line_count,
  output logic        field,
  output logic        field_start,
  output logic [15:0] underrun_count
);

  localparam logic [8:0] PIX_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] LAST_F1  = 9'(V_LINES_F1 - 1);
  localparam logic [8:0] LAST_F0  = 9'(V_LINES_F0 - 1);
  localparam logic [8:0] W_SYNC   = 9'(H_SYNC);
  localparam logic [8:0] W_EQ     = 9'(H_EQ);
  localparam logic [8:0] W_SERR   = 9'(H_SERR);
  localparam logic [8:0] HALF     = 9'(H_HALF);
  localparam logic [8:0] ACT_F    = 9'(H_ACT_FIRST);
  localparam logic [8:0] ACT_L    = 9'(H_ACT_LAST);

  logic [8:0] pix_nx, line_nx;
  logic       field_nx, pix_wrap, line_wrap, start_nx;
  line_type_t lt_nx;
  logic [8:0] w_first, w_second;
  logic       has_second, low_nx, win_nx;

  logic       enable_q;
  logic       data_win_q;
  logic [1:0] level_base_q;

  // Next counter state
  always_comb begin
    pix_wrap  = (pixel_count == PIX_LAST);
    line_wrap = pix_wrap && (line_count == (field ? LAST_F1 : LAST_F0));
    pix_nx    = pix_wrap ? 9'd0 : pixel_count + 9'd1;
    line_nx   = line_wrap ? 9'd0 : (pix_wrap ? line_count + 9'd1 : line_count);
    field_nx  = line_wrap ? ~field : field;
    start_nx  = (pix_nx == 9'd0) && (line_nx == 9'd0);
  end

  ntsc_line_classifier #(
    .V_ACT_FIRST (V_ACT_FIRST),
    .V_ACT_LAST  (V_ACT_LAST)
  ) u_classifier (
    .field      (field_nx),
    .line_count (line_nx),
    .line_type  (lt_nx)
  );

  // Sync-low widths for the first half-line and, on vertical-interval
  // lines, the second half-line starting at HALF.
  always_comb begin
    w_first    = W_SYNC;
    w_second   = 9'd0;
    has_second = 1'b1;
    case (lt_nx)
      LT_EQ:           begin w_first = W_EQ;   w_second = W_EQ;   end
      LT_SERR:         begin w_first = W_SERR; w_second = W_SERR; end
      LT_HALF_EQ_SERR: begin w_first = W_EQ;   w_second = W_SERR; end
      LT_HALF_SERR_EQ: begin w_first = W_SERR; w_second = W_EQ;   end
      default:         has_second = 1'b0;
    endcase
    low_nx = (pix_nx < w_first) ||
             (has_second && pix_nx >= HALF && pix_nx < (HALF + w_second));
    win_nx = (lt_nx == LT_ACTIVE) && (pix_nx >= ACT_F) && (pix_nx <= ACT_L);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_count    <= 9'd0;
      line_count     <= 9'd0;
      field          <= 1'b1;
      sync           <= 1'b0;
      level_base_q   <= LVL_SYNC;
      data_win_q     <= 1'b0;
      field_start    <= 1'b0;
      enable_q       <= 1'b0;
      underrun_count <= 16'd0;
    end else begin
      pixel_count <= pix_nx;
      line_count  <= line_nx;
      field       <= field_nx;
      field_start <= start_nx;
      sync        <= ~low_nx;
      if (start_nx) enable_q <= enable;
      // The window never contains pixel 0, so the current latch is valid.
      data_win_q  <= win_nx && enable_q;
      if (low_nx)      level_base_q <= LVL_SYNC;
      else if (win_nx) level_base_q <= LVL_IDLE;
      else             level_base_q <= LVL_BLANK;
      if (data_win_q && fifo_empty && underrun_count != 16'hFFFF)
        underrun_count <= underrun_count + 16'd1;
    end
  end

  assign fifo_rdreq = data_win_q && !fifo_empty;
  assign level_sel  = fifo_rdreq ? LVL_DATA : level_base_q;

endmodule
